bus_arbiter: RTL

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/bus_arbiter.sv
// ----------------------------------------------------------------------------
// bus_arbiter
//
// Two-master bus arbiter with round-robin tie breaking, a bounded hold
// time and a mandatory turnaround cycle between owners.
//
// A master raises its request and keeps it high for the whole transaction.
// It may mark its final cycle with last_mx. The current owner keeps the bus
// until one of these happens:
//   - it drops its request,
//   - it marks its last cycle, or
//   - it has held the bus for MAX_HOLD cycles while the other master waits.
// Ownership never moves directly from one master to the other. Every hand
// over goes through IDLE, so both grants are low for at least one cycle.
//
// Parameters
//   MAX_HOLD  grant cycles allowed before a forced release (2..256)
//   CNT_W     hold-counter width, 2**CNT_W >= MAX_HOLD
//
// Ports
//   clk            rising-edge clock
//   rst            synchronous active-high reset
//   req_m1/req_m2  bus requests from master1 / master2
//   last_m1/last_m2  final-cycle markers, only honoured while granted
//   gnt_m1/gnt_m2  registered grants, mutually exclusive
//   master_select  bus mux select (0 = master1, 1 = master2), held in IDLE
//   bus_busy       registered OR of the two grants
//   timeout        one-cycle pulse alongside a forced release
// ----------------------------------------------------------------------------
module bus_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic req_m1,
  input  logic req_m2,
  input  logic last_m1,
  input  logic last_m2,
  output logic gnt_m1,
  output logic gnt_m2,
  output logic master_select,
  output logic bus_busy,
  output logic timeout
);

  // Counter value reached on the MAX_HOLD-th grant cycle.
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OWN_M1 = 2'd1,
    OWN_M2 = 2'd2
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_last_owner;     // 0 = master1, 1 = master2
  logic             r_gnt_m1;
  logic             r_gnt_m2;
  logic             r_master_select;
  logic             r_bus_busy;
  logic             r_timeout;

  // Per-master views of the inputs, indexed 0 = master1, 1 = master2, so the
  // ownership logic below can be written once for both owners.
  logic [1:0] w_req;
  logic [1:0] w_last;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_master
      if (gi == 0) begin : g_m1
        assign w_req[gi]  = req_m1;
        assign w_last[gi] = last_m1;
      end else begin : g_m2
        assign w_req[gi]  = req_m2;
        assign w_last[gi] = last_m2;
      end
    end
  endgenerate

  // Index of the current owner. It is only meaningful in OWN_M1 / OWN_M2.
  logic w_owner;
  logic w_own_req;
  logic w_own_last;
  logic w_other_req;
  logic w_hold_full;
  logic w_forced;
  logic w_release;
  logic w_any_req;
  logic w_pick;

  assign w_owner     = (r_state == OWN_M2);
  assign w_own_req   = w_req[w_owner];
  assign w_own_last  = w_last[w_owner];
  assign w_other_req = w_req[~w_owner];
  assign w_hold_full = (r_cnt == HOLD_LAST);

  // A release counts as forced only if the owner would otherwise have kept
  // the bus. A voluntary release on the same cycle does not raise timeout.
  assign w_forced  = w_hold_full & w_other_req & w_own_req & ~w_own_last;
  assign w_release = ~w_own_req | w_own_last | w_forced;

  // IDLE choice. A single requester wins outright. On a tie, the master
  // that did not own the bus last time wins.
  assign w_any_req = |w_req;
  assign w_pick    = (w_req[0] & w_req[1]) ? ~r_last_owner : w_req[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= IDLE;
      r_cnt           <= '0;
      r_last_owner    <= 1'b1;        // master1 wins the first tie
      r_gnt_m1        <= 1'b0;
      r_gnt_m2        <= 1'b0;
      r_master_select <= 1'b0;
      r_bus_busy      <= 1'b0;
      r_timeout       <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (w_any_req) begin
            r_state         <= w_pick ? OWN_M2 : OWN_M1;
            r_gnt_m1        <= ~w_pick;
            r_gnt_m2        <= w_pick;
            r_master_select <= w_pick;
            r_bus_busy      <= 1'b1;
            r_last_owner    <= w_pick;
          end
        end

        OWN_M1, OWN_M2: begin
          if (w_release) begin
            // master_select keeps its value so the mux stays stable in IDLE.
            r_state    <= IDLE;
            r_gnt_m1   <= 1'b0;
            r_gnt_m2   <= 1'b0;
            r_bus_busy <= 1'b0;
            r_timeout  <= w_forced;
            r_cnt      <= '0;
          end else if (!w_hold_full) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        default: begin
          r_state    <= IDLE;
          r_gnt_m1   <= 1'b0;
          r_gnt_m2   <= 1'b0;
          r_bus_busy <= 1'b0;
          r_cnt      <= '0;
        end
      endcase
    end
  end

  assign gnt_m1        = r_gnt_m1;
  assign gnt_m2        = r_gnt_m2;
  assign master_select = r_master_select;
  assign bus_busy      = r_bus_busy;
  assign timeout       = r_timeout;

  // Structural invariants of the registered outputs.
  a_params : assert property (@(posedge clk)
    (MAX_HOLD >= 2) && (MAX_HOLD <= 256) && ((2 ** CNT_W) >= MAX_HOLD));

  a_grant_exclusive : assert property (@(posedge clk) disable iff (rst)
    !(r_gnt_m1 && r_gnt_m2));

  a_busy_matches : assert property (@(posedge clk) disable iff (rst)
    r_bus_busy == (r_gnt_m1 | r_gnt_m2));

endmodule
